// File: rtl/control_contador4b_pkg.sv
// control_contador4b_pkg: mode constants and FSM state encoding shared by the
// command sequencer and its pulse counter.
`default_nettype none

package control_contador4b_pkg;

  localparam logic [1:0] MODO_ARRIBA = 2'b00;
  localparam logic [1:0] MODO_ABAJO  = 2'b01;
  localparam logic [1:0] MODO_ABAJO3 = 2'b10;
  localparam logic [1:0] MODO_CARGA  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CARGA = 2'd1,
    CORRE = 2'd2,
    FIN   = 2'd3
  } estado_t;

endpackage

`default_nettype wire

// File: rtl/control_contador4b_contador_pulsos.sv
// contador_pulsos: saturating RCO-pulse counter with synchronous clear and a
// match flag that fires when the pending increment reaches the target.
`default_nettype none

module contador_pulsos #(
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  input  logic [VW-1:0] objetivo,
  output logic [VW-1:0] cuenta,
  output logic          match
);

  localparam logic [VW-1:0] UNO = {{(VW-1){1'b0}}, 1'b1};

  logic [VW-1:0] siguiente;

  always_comb begin
    siguiente = (cuenta == {VW{1'b1}}) ? cuenta : cuenta + UNO;
  end

  assign match = inc && (siguiente == objetivo);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cuenta <= '0;
    end else if (inc) begin
      cuenta <= siguiente;
    end
  end

endmodule

`default_nettype wire

// File: rtl/control_contador4b.sv
// control_contador4b: command sequencer driving enb/D/modo of a 4-bit counter,
// counting RCO pulses until a programmed target and reporting the final Q.
`default_nettype none

module control_contador4b
  import control_contador4b_pkg::*;
#(
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_modo,
  input  logic          cmd_cargar,
  input  logic [3:0]    cmd_dato,
  input  logic [VW-1:0] cmd_vueltas,
  input  logic          abortar,
  output logic          enb,
  output logic [3:0]    D,
  output logic [1:0]    modo,
  input  logic [3:0]    Q,
  input  logic          RCO,
  output logic          ocupado,
  output logic          listo,
  output logic [3:0]    q_final,
  output logic [VW-1:0] rco_cuenta
);

  estado_t       estado, sig;
  logic [1:0]    l_modo;
  logic [VW-1:0] l_vueltas;
  logic          aceptar, clr, inc, match;
  logic [3:0]    d_sig;
  logic [1:0]    modo_sig;

  assign cmd_ready = (estado == IDLE) && !reset;
  assign aceptar   = cmd_valid && cmd_ready;

  contador_pulsos #(.VW(VW)) u_pulsos (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .inc      (inc),
    .objetivo (l_vueltas),
    .cuenta   (rco_cuenta),
    .match    (match)
  );

  always_comb begin
    sig      = estado;
    clr      = 1'b0;
    inc      = 1'b0;
    d_sig    = D;
    modo_sig = modo;
    case (estado)
      IDLE: begin
        if (aceptar) begin
          clr = 1'b1;
          if (cmd_modo == MODO_CARGA || cmd_cargar) begin
            sig      = CARGA;
            d_sig    = cmd_dato;
            modo_sig = MODO_CARGA;
          end else begin
            sig      = CORRE;
            modo_sig = cmd_modo;
          end
        end
      end
      CARGA: begin
        if (abortar) begin
          sig = IDLE;
        end else if (l_modo == MODO_CARGA || l_vueltas == '0) begin
          sig = FIN;
        end else begin
          sig      = CORRE;
          modo_sig = l_modo;
        end
      end
      CORRE: begin
        // Abort takes priority over a completing RCO, and freezes the count.
        if (abortar) begin
          sig = IDLE;
        end else if (l_vueltas == '0) begin
          sig = FIN;
        end else if (RCO) begin
          inc = 1'b1;
          if (match) sig = FIN;
        end
      end
      FIN:     sig = IDLE;
      default: sig = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado    <= IDLE;
      enb       <= 1'b0;
      D         <= 4'd0;
      modo      <= MODO_ARRIBA;
      ocupado   <= 1'b0;
      listo     <= 1'b0;
      q_final   <= 4'd0;
      l_modo    <= MODO_ARRIBA;
      l_vueltas <= '0;
    end else begin
      estado  <= sig;
      enb     <= (sig == CARGA) || (sig == CORRE);
      ocupado <= (sig != IDLE);
      listo   <= (sig == FIN);
      D       <= d_sig;
      modo    <= modo_sig;
      if (estado == FIN) q_final <= Q;
      if (aceptar) begin
        l_modo    <= cmd_modo;
        l_vueltas <= cmd_vueltas;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_control_contador4b.sv
// tb_control_contador4b: directed bench with a behavioural 4-bit counter model
// attached to enb/D/modo; per-cycle vector table plus multi-cycle sequences.
`default_nettype none

module tb_control_contador4b;

  localparam int VW = 8;

  logic          clk = 1'b0;
  logic          reset, cmd_valid, cmd_cargar, abortar;
  logic [1:0]    cmd_modo;
  logic [3:0]    cmd_dato;
  logic [VW-1:0] cmd_vueltas;
  logic          cmd_ready, enb, ocupado, listo;
  logic [3:0]    D, q_final;
  logic [1:0]    modo;
  logic [VW-1:0] rco_cuenta;
  logic [3:0]    Q = 4'd0;
  logic          RCO;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_contador4b #(.VW(VW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_modo(cmd_modo), .cmd_cargar(cmd_cargar), .cmd_dato(cmd_dato),
    .cmd_vueltas(cmd_vueltas), .abortar(abortar), .enb(enb), .D(D),
    .modo(modo), .Q(Q), .RCO(RCO), .ocupado(ocupado), .listo(listo),
    .q_final(q_final), .rco_cuenta(rco_cuenta)
  );

  // Counter model: up, down, down-by-3, load; RCO flags the wrapping cycle.
  always_ff @(posedge clk) begin
    if (reset) Q <= 4'd0;
    else if (enb) begin
      case (modo)
        2'b00:   Q <= Q + 4'd1;
        2'b01:   Q <= Q - 4'd1;
        2'b10:   Q <= Q - 4'd3;
        default: Q <= D;
      endcase
    end
  end
  assign RCO = enb && ((modo == 2'b00 && Q == 4'd15) ||
                       (modo == 2'b01 && Q == 4'd0)  ||
                       (modo == 2'b10 && Q < 4'd3));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       valid;
    logic [1:0] c_modo;
    logic       cargar;
    logic [3:0] dato;
    logic [7:0] vueltas;
    logic       ready, ocu, lis, en;
    logic [1:0] mo;
    logic [3:0] d;
    logic       chk_qf;
    logic [3:0] qf;
    logic [7:0] cuenta;
  } vec_t;

  vec_t tabla [9];

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      cmd_valid   = tabla[i].valid;
      cmd_modo    = tabla[i].c_modo;
      cmd_cargar  = tabla[i].cargar;
      cmd_dato    = tabla[i].dato;
      cmd_vueltas = tabla[i].vueltas;
      abortar     = 1'b0;
      @(negedge clk);
      check($sformatf("row%0d_ready", i), 32'(cmd_ready), 32'(tabla[i].ready));
      check($sformatf("row%0d_ocupado", i), 32'(ocupado), 32'(tabla[i].ocu));
      check($sformatf("row%0d_listo", i), 32'(listo), 32'(tabla[i].lis));
      check($sformatf("row%0d_enb", i), 32'(enb), 32'(tabla[i].en));
      check($sformatf("row%0d_modo", i), 32'(modo), 32'(tabla[i].mo));
      check($sformatf("row%0d_D", i), 32'(D), 32'(tabla[i].d));
      check($sformatf("row%0d_cuenta", i), 32'(rco_cuenta), 32'(tabla[i].cuenta));
      if (tabla[i].chk_qf)
        check($sformatf("row%0d_q_final", i), 32'(q_final), 32'(tabla[i].qf));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nlisto, primero, nrco, malo;
    // valid modo cargar dato vueltas | ready ocu listo enb modo D chk_qf qf cuenta
    tabla[0] = '{1'b1, 2'b11, 1'b0, 4'b1010, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 4'b1010, 1'b1, 4'd0,    8'd0};
    tabla[1] = '{1'b0, 2'b11, 1'b0, 4'b1010, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 4'b1010, 1'b1, 4'd0,    8'd0};
    tabla[2] = '{1'b0, 2'b11, 1'b0, 4'b1010, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 4'b1010, 1'b1, 4'b1010, 8'd0};
    tabla[3] = '{1'b1, 2'b00, 1'b0, 4'b0000, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 4'b1111, 1'b0, 4'd0,    8'd0};
    tabla[4] = '{1'b1, 2'b00, 1'b0, 4'b0000, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 4'b1111, 1'b0, 4'd0,    8'd0};
    tabla[5] = '{1'b1, 2'b00, 1'b0, 4'b0000, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1111, 1'b0, 4'd0,    8'd0};
    tabla[6] = '{1'b1, 2'b00, 1'b0, 4'b0000, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 4'b1111, 1'b0, 4'd0,    8'd0};
    tabla[7] = '{1'b0, 2'b00, 1'b0, 4'b0000, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 4'b1111, 1'b0, 4'd0,    8'd0};
    tabla[8] = '{1'b0, 2'b00, 1'b0, 4'b0000, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1111, 1'b0, 4'd0,    8'd0};

    reset = 1'b1; cmd_valid = 1'b0; cmd_cargar = 1'b0; abortar = 1'b0;
    cmd_modo = 2'b00; cmd_dato = 4'd0; cmd_vueltas = '0;
    repeat (2) @(negedge clk);
    check("rst_enb", 32'(enb), 0);
    check("rst_D", 32'(D), 0);
    check("rst_modo", 32'(modo), 0);
    check("rst_ocupado", 32'(ocupado), 0);
    check("rst_listo", 32'(listo), 0);
    check("rst_q_final", 32'(q_final), 0);
    check("rst_cuenta", 32'(rco_cuenta), 0);
    reset = 1'b0;
    #1 check("rst_ready", 32'(cmd_ready), 1);

    // Load-only command
    run_rows(0, 2);

    // Preload 1110, count up, one RCO at the wrap
    cmd_valid = 1'b1; cmd_cargar = 1'b1; cmd_dato = 4'b1110; cmd_modo = 2'b00; cmd_vueltas = 8'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("up_carga_enb", 32'(enb), 1);
    check("up_carga_modo", 32'(modo), 3);
    check("up_carga_D", 32'(D), 14);
    n = 1;
    while (!listo && n < 10) begin @(negedge clk); n++; end
    check("up_listo_latency", 32'(n), 4);
    check("up_cuenta", 32'(rco_cuenta), 1);
    check("up_enb_fin", 32'(enb), 0);
    @(negedge clk);
    check("up_q_final", 32'(q_final), 0);
    check("up_ready", 32'(cmd_ready), 1);

    // Count down from 0, three wraps
    cmd_valid = 1'b1; cmd_cargar = 1'b0; cmd_modo = 2'b01; cmd_vueltas = 8'd3;
    nlisto = 0; primero = 0; nrco = 0; malo = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (RCO) nrco++;
      if (listo) begin nlisto++; if (primero == 0) primero = k; end
      if (k <= 34 && !ocupado) malo++;
      if (k == 34) check("down_enb_after_third", 32'(enb), 0);
    end
    check("down_listo_cycle", 32'(primero), 34);
    check("down_listo_count", 32'(nlisto), 1);
    check("down_rco_seen", 32'(nrco), 3);
    check("down_ocupado_gaps", 32'(malo), 0);
    check("down_cuenta", 32'(rco_cuenta), 3);
    check("down_q_final", 32'(q_final), 15);

    // Abort after two RCO pulses
    cmd_valid = 1'b1; cmd_cargar = 1'b1; cmd_dato = 4'b1111; cmd_modo = 2'b00; cmd_vueltas = 8'd5;
    n = 0; nlisto = 0;
    while (rco_cuenta != 8'd2 && n < 40) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (listo) nlisto++;
      n++;
    end
    check("abort_reach_two", 32'(rco_cuenta), 2);
    abortar = 1'b1;
    @(negedge clk);
    abortar = 1'b0;
    check("abort_ocupado", 32'(ocupado), 0);
    check("abort_enb", 32'(enb), 0);
    check("abort_ready", 32'(cmd_ready), 1);
    check("abort_cuenta", 32'(rco_cuenta), 2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (listo) nlisto++;
    end
    check("abort_no_listo", 32'(nlisto), 0);
    check("abort_cuenta_frozen", 32'(rco_cuenta), 2);

    // Zero target, cmd_valid held high across two commands
    run_rows(3, 8);

    // Reset in the middle of a run
    cmd_valid = 1'b1; cmd_cargar = 1'b0; cmd_modo = 2'b00; cmd_vueltas = 8'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_ocupado", 32'(ocupado), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_enb", 32'(enb), 0);
    check("mrst_D", 32'(D), 0);
    check("mrst_modo", 32'(modo), 0);
    check("mrst_ocupado", 32'(ocupado), 0);
    check("mrst_listo", 32'(listo), 0);
    check("mrst_q_final", 32'(q_final), 0);
    check("mrst_cuenta", 32'(rco_cuenta), 0);
    #1 check("mrst_ready", 32'(cmd_ready), 1);
    nlisto = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (listo) nlisto++;
    end
    check("mrst_no_listo", 32'(nlisto), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
